// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, counter types and sync FSM states.
// Used by the sync decoder and the sync pulse generator.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int GOOD_W = 4;

  localparam int DEF_TOTAL_COLS = 800;
  localparam int DEF_TOTAL_ROWS = 525;
  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_LOCK_FRAMES = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t col;
    cnt_t row;
  } pos_t;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } sync_state_e;

  function automatic cnt_t wrap_inc(
    input cnt_t v,
    input cnt_t max
  );
    return (v == max) ? '0 : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: q is d delayed one cycle,
// rise is high while d is high and q is still low.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers col/row from active-high HSync/VSync, flags timing errors
// and tracks lock. Ports: clk, rst_n, HSync, VSync in; HSync_o,
// VSync_o, col, row, video_active, frame_start, locked, sync_err out.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             HSync,
  input  logic             VSync,
  output logic             HSync_o,
  output logic             VSync_o,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             video_active,
  output logic             frame_start,
  output logic             locked,
  output logic             sync_err
);

  localparam cnt_t COL_MAX = cnt_t'(TOTAL_COLS - 1);
  localparam cnt_t ROW_MAX = cnt_t'(TOTAL_ROWS - 1);
  localparam cnt_t ACT_C = cnt_t'(ACTIVE_COLS);
  localparam cnt_t ACT_R = cnt_t'(ACTIVE_ROWS);
  localparam logic [GOOD_W-1:0] LOCK_N =
    GOOD_W'(LOCK_FRAMES);

  logic hs_q;
  logic vs_q;
  logic hs_rise;
  logic vs_rise;
  logic hs_only;
  logic free_run;

  edge_detect u_hs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (HSync),
    .q    (hs_q),
    .rise (hs_rise)
  );

  edge_detect u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (VSync),
    .q    (vs_q),
    .rise (vs_rise)
  );

  assign hs_only  = hs_rise & ~vs_rise;
  assign free_run = ~hs_rise & ~vs_rise;

  pos_t pos_q;
  pos_t pos_d;
  logic col_end;
  logic frame_end;
  logic err_d;
  logic first_q;

  assign col_end   = (pos_q.col == COL_MAX);
  assign frame_end = col_end && (pos_q.row == ROW_MAX);

  // VSync rise wins over HSync rise. Any path that wraps the
  // counters out of the last pixel without a VSync rise is an
  // error, including an HSync-driven row wrap.
  always_comb begin
    pos_d = pos_q;
    err_d = 1'b0;
    unique case (1'b1)
      vs_rise: begin
        pos_d = '0;
        err_d = ~frame_end & ~first_q;
      end
      hs_only: begin
        pos_d.col = '0;
        pos_d.row = wrap_inc(pos_q.row, ROW_MAX);
        err_d = ~col_end | frame_end;
      end
      free_run: begin
        pos_d.col = wrap_inc(pos_q.col, COL_MAX);
        if (col_end) begin
          pos_d.row = wrap_inc(pos_q.row, ROW_MAX);
        end
        err_d = frame_end;
      end
      default: ;
    endcase
  end

  sync_state_e state_q;
  sync_state_e state_d;
  logic [GOOD_W-1:0] good_q;
  logic [GOOD_W-1:0] good_d;
  logic [GOOD_W-1:0] good_inc;
  logic bad_q;
  logic bad_d;

  assign good_inc = good_q + GOOD_W'(1);

  // bad_q remembers an error anywhere in the current frame so the
  // VSync rise that closes it is not counted as good.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = vs_rise ? 1'b0 : (bad_q | err_d);
    unique case (state_q)
      ST_UNLOCKED: begin
        if (vs_rise) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (vs_rise && !err_d && !bad_q) begin
          good_d = good_inc;
          if (good_inc == LOCK_N) begin
            state_d = ST_LOCKED;
          end
        end else if (vs_rise || err_d) begin
          good_d = '0;
        end
      end
      ST_LOCKED: begin
        if (err_d) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        good_d  = '0;
      end
    endcase
  end

  logic va_q;
  logic fs_q;
  logic err_q;
  logic lock_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q   <= '0;
      first_q <= 1'b1;
      state_q <= ST_UNLOCKED;
      good_q  <= '0;
      bad_q   <= 1'b0;
      va_q    <= 1'b0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      if (vs_rise) begin
        first_q <= 1'b0;
      end
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      va_q    <= (pos_d.col < ACT_C) &&
                 (pos_d.row < ACT_R);
      fs_q    <= vs_rise;
      err_q   <= err_d;
      lock_q  <= (state_d == ST_LOCKED);
    end
  end

  assign HSync_o      = hs_q;
  assign VSync_o      = vs_q;
  assign col          = pos_q.col;
  assign row          = pos_q.row;
  assign video_active = va_q;
  assign frame_start  = fs_q;
  assign sync_err     = err_q;
  assign locked       = lock_q;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, columns per line including blanking.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, lines per frame including blanking.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, visible columns.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, visible lines.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required to declare lock (range 1..15).
REQ-006 SHALL have port clk  input  1  pixel clock, the only clock.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port HSync  input  1  line sync from the generator, high while the line is in its active region, same clock domain.
REQ-009 SHALL have port VSync  input  1  frame sync from the generator, high while the frame is in its active region, same clock domain.
REQ-010 SHALL have port HSync_o  output  1  HSync delayed one cycle, aligned with col/row.
REQ-011 SHALL have port VSync_o  output  1  VSync delayed one cycle, aligned with col/row.
REQ-012 SHALL have port col  output  10  recovered column, 0..TOTAL_COLS-1.
REQ-013 SHALL have port row  output  10  recovered row, 0..TOTAL_ROWS-1.
REQ-014 SHALL have port video_active  output  1  high when col < ACTIVE_COLS and row < ACTIVE_ROWS.
REQ-015 SHALL have port frame_start  output  1  one-cycle pulse, high in the cycle col=0,row=0 follows a VSync rise.
REQ-016 SHALL have port locked  output  1  high while the input timing matches the parameters.
REQ-017 SHALL have port sync_err  output  1  one-cycle pulse on any timing mismatch.

Function
REQ-018 SHALL detect edges as input high while the one-cycle-delayed copy is low; all outputs registered; latency from input edge to counter update is exactly 1 cycle.
REQ-019 On a VSync rise, SHALL load col=0, row=0 and pulse frame_start; VSync rise takes priority over a simultaneous HSync rise, and the HSync check is skipped that cycle.
REQ-020 On an HSync rise without a VSync rise, SHALL load col=0 and row=row+1, wrapping TOTAL_ROWS-1 to 0.
REQ-021 Otherwise col SHALL increment, wrapping TOTAL_COLS-1 to 0; on the wrap, row increments, wrapping TOTAL_ROWS-1 to 0.
REQ-022 HSync rise while col != TOTAL_COLS-1 (pre-update) SHALL pulse sync_err; the counters still resynchronise per REQ-020.
REQ-023 VSync rise while (col,row) != (TOTAL_COLS-1,TOTAL_ROWS-1) SHALL pulse sync_err, except the first VSync rise after reset.
REQ-024 Counters wrapping from (TOTAL_COLS-1,TOTAL_ROWS-1) with no VSync rise that cycle SHALL pulse sync_err (missing frame sync).
REQ-025 The FSM SHALL have states UNLOCKED, ACQUIRE and LOCKED.
REQ-026 UNLOCKED SHALL go to ACQUIRE on the first VSync rise, with good_frames=0.
REQ-027 In ACQUIRE, each VSync rise without error in the preceding frame SHALL increment good_frames; on reaching LOCK_FRAMES the FSM goes to LOCKED.
REQ-028 In ACQUIRE, sync_err SHALL clear good_frames and stay in ACQUIRE.
REQ-029 LOCKED SHALL go to ACQUIRE on sync_err, with good_frames=0.
REQ-030 locked SHALL be 1 only in LOCKED; it rises in the cycle after the qualifying VSync rise and falls in the same cycle sync_err pulses.
REQ-031 col, row, video_active, HSync_o and VSync_o SHALL be valid in every state; the counters free-run when unlocked.

Reset
REQ-032 While rst_n=0 at a clk edge: col=0, row=0, HSync_o=0, VSync_o=0, frame_start=0, sync_err=0, locked=0, video_active=0.
REQ-033 While rst_n=0 at a clk edge: state=UNLOCKED, good_frames=0, edge-history registers=0, and the first-VSync flag is set.
REQ-034 Reset asserted mid-frame SHALL take effect at the next edge and override every other event.

Structure
REQ-035 The TOTAL_/ACTIVE_ timing defaults, the 10-bit counter width and the FSM state enum SHALL live in shared package vga_pkg, also used by sync_pulse_gen.
REQ-036 One sub-module, edge_detect, SHALL be used (1-bit registered rise detector, instantiated for HSync and VSync); everything else is flat.

Verification (TOTAL_COLS=10, TOTAL_ROWS=6, ACTIVE_COLS=8, ACTIVE_ROWS=4, LOCK_FRAMES=2, stimulus from sync_pulse_gen with matching parameters)
REQ-037 Reset release, clean timing -> frame_start on the first VSync rise, locked=1 one cycle after the third VSync rise (two good frames), sync_err never pulses.
REQ-038 Locked, HSync rise injected at col=4 -> sync_err pulse, locked=0 that cycle, next cycle col=0 and row incremented, relock after 2 further clean frames.
REQ-039 Locked, one VSync pulse suppressed -> sync_err when counters wrap from (9,5), locked drops, counters continue at (0,0).
REQ-040 HSync and VSync rising in the same cycle at (9,5) -> col=0, row=0, frame_start=1, no sync_err.
REQ-041 Counter sweep -> video_active high exactly for col 0..7 and row 0..3, i.e. 32 cycles per frame.
REQ-042 rst_n pulled low for 1 cycle at (5,2) while locked -> all outputs 0 next cycle, UNLOCKED, locked again only after the first VSync rise plus 2 good frames.
